// File: rtl/crg_rst_seq.sv
// Reset sequencer: holds all domain resets, waits for PLL lock, then
// releases domains one at a time with per-domain programmable delays.
module crg_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

module crg_rst_seq #(
  parameter int N_DOM    = 4,
  parameter int CNT_W    = 8,
  parameter int HOLD_CYC = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   pll_lock,
  input  logic                   sw_rst_req,
  input  logic [N_DOM*CNT_W-1:0] dly_cfg,
  output logic [N_DOM-1:0]       dom_rst_n,
  output logic                   busy,
  output logic                   done
);

  localparam int IDX_W = (N_DOM > 1) ? $clog2(N_DOM) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DOM - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);

  typedef enum logic [1:0] {
    S_HOLD,
    S_WAIT,
    S_REL,
    S_RUN
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [CNT_W-1:0] hcnt, hcnt_n;
  logic [IDX_W-1:0] idx, idx_n;
  logic [N_DOM-1:0] dom_n;
  logic             done_n;
  logic             busy_n;
  logic             lock_s;
  logic             req_s;
  logic             evt;
  logic [CNT_W-1:0] fld [N_DOM];

  crg_sync2 u_sync_lock (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (pll_lock),
    .q     (lock_s)
  );

  crg_sync2 u_sync_req (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (sw_rst_req),
    .q     (req_s)
  );

  for (genvar i = 0; i < N_DOM; i++) begin : g_fld
    assign fld[i] = dly_cfg[i*CNT_W +: CNT_W];
  end

  assign evt = !lock_s || req_s;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    hcnt_n  = hcnt;
    idx_n   = idx;
    dom_n   = dom_rst_n;
    done_n  = done;
    unique case (state)
      S_HOLD: begin
        dom_n  = '0;
        done_n = 1'b0;
        if (hcnt == HOLD_LAST) begin
          hcnt_n  = '0;
          state_n = S_WAIT;
        end else begin
          hcnt_n = hcnt + 1'b1;
        end
      end
      S_WAIT: begin
        if (lock_s && !req_s) begin
          cnt_n   = fld[0];
          idx_n   = '0;
          state_n = S_REL;
        end
      end
      S_REL: begin
        // an abort outranks a release landing on the same edge
        if (evt) begin
          state_n = S_HOLD;
          dom_n   = '0;
          done_n  = 1'b0;
          cnt_n   = '0;
          idx_n   = '0;
          hcnt_n  = '0;
        end else if (cnt == '0) begin
          dom_n[idx] = 1'b1;
          if (idx == IDX_LAST) begin
            state_n = S_RUN;
            done_n  = 1'b1;
          end else begin
            idx_n = idx + 1'b1;
            cnt_n = fld[idx + 1'b1];
          end
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      S_RUN: begin
        if (evt) begin
          state_n = S_HOLD;
          dom_n   = '0;
          done_n  = 1'b0;
          cnt_n   = '0;
          idx_n   = '0;
          hcnt_n  = '0;
        end
      end
      default: begin
        state_n = S_HOLD;
        dom_n   = '0;
        done_n  = 1'b0;
        hcnt_n  = '0;
      end
    endcase
    busy_n = ~&dom_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_HOLD;
      cnt       <= '0;
      hcnt      <= '0;
      idx       <= '0;
      dom_rst_n <= '0;
      done      <= 1'b0;
      busy      <= 1'b1;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      hcnt      <= hcnt_n;
      idx       <= idx_n;
      dom_rst_n <= dom_n;
      done      <= done_n;
      busy      <= busy_n;
    end
  end

endmodule

// File: doc/crg_rst_seq.md
CRG_RST_SEQ -- requirements
Module: crg_rst_seq

Interface
REQ-001 SHALL have parameter N_DOM, default 4, meaning the number of sequenced reset domains (1..8).
REQ-002 SHALL have parameter CNT_W, default 8, meaning the width of each per-domain release delay field.
REQ-003 SHALL have parameter HOLD_CYC, default 16, meaning the minimum cycles all domain resets stay asserted after any reset event (1..2^CNT_W-1).
REQ-004 SHALL have port clk  input  1  single clock for all logic.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port pll_lock  input  1  asynchronous PLL lock indication.
REQ-007 SHALL have port sw_rst_req  input  1  asynchronous software reset request, level-sensitive, active-high.
REQ-008 SHALL have port dly_cfg  input  N_DOM*CNT_W  per-domain release delay; field i is bits [i*CNT_W +: CNT_W]; quasi-static, sampled only on load.
REQ-009 SHALL have port dom_rst_n  output  N_DOM  active-low domain resets; bit 0 released first.
REQ-010 SHALL have port busy  output  1  high whenever any dom_rst_n bit is 0.
REQ-011 SHALL have port done  output  1  high only in RUN.

Function
REQ-012 SHALL synchronize pll_lock and sw_rst_req each through a 2-flop crg_sync2 instance on clk (lock_s, req_s); 2-cycle input latency.
REQ-013 SHALL implement FSM states HOLD, WAIT, REL, RUN; all outputs registered.
REQ-014 HOLD: all dom_rst_n=0; hold counter counts HOLD_CYC cycles, then goes to WAIT.
REQ-015 WAIT: when lock_s=1 and req_s=0, load cnt from dly_cfg field 0, set idx=0, go to REL; otherwise stay.
REQ-016 REL: cnt decrements each cycle; when cnt==0, set dom_rst_n[idx]=1 in the next cycle; domain i is therefore released dly_cfg[i]+1 cycles after its load.
REQ-017 REL: on a release with idx<N_DOM-1, increment idx and load cnt from field idx+1 in the same cycle; with idx==N_DOM-1, go to RUN.
REQ-018 Delay field 0 SHALL release the domain one cycle after load; no cycle gap between consecutive loads.
REQ-019 RUN: done=1 and all dom_rst_n=1; stay until a reset event.
REQ-020 A reset event is lock_s=0 or req_s=1 in REL or RUN; the next cycle SHALL have all dom_rst_n=0, done=0, and state HOLD with the hold counter cleared.
REQ-021 In HOLD, events SHALL NOT restart the hold counter; WAIT gates exit on lock_s/req_s.
REQ-022 idx and cnt widths SHALL hold N_DOM-1 and 2^CNT_W-1 without wrap; cnt SHALL never decrement below 0.
REQ-023 Simultaneous release and event in the same cycle: the event wins, and no further dom_rst_n bit rises.
REQ-024 dom_rst_n SHALL be monotonic during a sequence: bits rise in index order only and never individually fall.

Reset
REQ-025 rst_n low SHALL asynchronously force state=HOLD, dom_rst_n=0, busy=1, done=0, cnt=0, idx=0, hold counter=0, and synchronizer flops=0.
REQ-026 rst_n release SHALL begin the HOLD count on the first clk edge after deassertion; mid-sequence assertion aborts the sequence immediately.

Verification
REQ-027 N_DOM=4, HOLD_CYC=16, dly_cfg={8'd3,8'd2,8'd1,8'd0}, pll_lock=1 from reset -> dom_rst_n goes 0001,0011,0111,1111 at 1,3,6,10 cycles after leaving WAIT; done=1 with 1111.
REQ-028 sw_rst_req pulsed for 3 cycles in RUN -> dom_rst_n=0000 three cycles after the rising edge (2 sync + 1), held for at least 16 cycles, then the full sequence repeats.
REQ-029 pll_lock low during REL after 0011 -> next cycle after lock_s falls gives 0000; WAIT persists until pll_lock returns, with no bit rising meanwhile.
REQ-030 All delay fields 8'hFF -> each domain released exactly 256 cycles after its load; no counter wrap.
REQ-031 rst_n asserted asynchronously mid-REL (between clk edges) -> dom_rst_n=0000 and busy=1 without a clock edge.
REQ-032 pll_lock held low after reset -> remain in WAIT indefinitely, with dom_rst_n=0000, busy=1, done=0.
